// File: rtl/led_sequencer.sv
// LED pattern sequencer: shadowed config, prescaled step ticks, four patterns
// (count, rotate, bounce, blink) with repeat counting and abort.
module led_sequencer #(
  parameter int unsigned STEP_W       = 32,
  parameter int unsigned DEFAULT_STEP = 10
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              CFG_VALID,
  output logic              CFG_READY,
  input  logic [1:0]        CFG_MODE,
  input  logic [STEP_W-1:0] CFG_STEP,
  input  logic [7:0]        CFG_REPEAT,
  input  logic              START,
  input  logic              STOP,
  output logic              BUSY,
  output logic              TICK,
  output logic              DONE,
  output logic [7:0]        LED
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  localparam logic [1:0] MODE_COUNT  = 2'd0;
  localparam logic [1:0] MODE_SHIFT  = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;
  localparam logic [1:0] MODE_BLINK  = 2'd3;

  state_e            state_q, state_d;
  logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
  logic [7:0]        seq_cnt_q, seq_cnt_d;
  logic [7:0]        led_q, led_d;
  logic              tick_q, tick_d;
  logic              done_q, done_d;
  logic              dir_q, dir_d;
  logic [1:0]        mode_q, mode_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [7:0]        repeat_q, repeat_d;

  logic [STEP_W-1:0] step_last;
  logic [7:0]        led_next;
  logic              dir_next;
  logic              seq_end;
  logic [1:0]        start_mode;

  // Next pattern and end-of-sequence are derived from the pre-advance LED value.
  always_comb begin
    led_next = led_q;
    dir_next = dir_q;
    seq_end  = 1'b0;
    case (mode_q)
      MODE_COUNT: begin
        led_next = led_q + 8'd1;
        seq_end  = (led_q == 8'hFF);
      end
      MODE_SHIFT: begin
        led_next = {led_q[6:0], led_q[7]};
        seq_end  = (led_q == 8'h80);
      end
      MODE_BOUNCE: begin
        if (!dir_q) begin
          led_next = {led_q[6:0], 1'b0};
          if (led_next == 8'h80) dir_next = 1'b1;
        end else begin
          led_next = {1'b0, led_q[7:1]};
          if (led_next == 8'h01) dir_next = 1'b0;
        end
        seq_end = dir_q && (led_q == 8'h02);
      end
      default: begin
        led_next = ~led_q;
        seq_end  = (led_q == 8'hFF);
      end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    step_cnt_d = step_cnt_q;
    seq_cnt_d  = seq_cnt_q;
    led_d      = led_q;
    tick_d     = 1'b0;
    done_d     = 1'b0;
    dir_d      = dir_q;
    mode_d     = mode_q;
    step_d     = step_q;
    repeat_d   = repeat_q;
    step_last  = (step_q == '0) ? '0 : step_q - 1'b1;
    start_mode = CFG_VALID ? CFG_MODE : mode_q;

    case (state_q)
      IDLE: begin
        if (CFG_VALID) begin
          mode_d   = CFG_MODE;
          step_d   = CFG_STEP;
          repeat_d = CFG_REPEAT;
        end
        if (STOP) begin
          led_d = '0;
        end else if (START) begin
          state_d    = RUN;
          step_cnt_d = '0;
          seq_cnt_d  = '0;
          dir_d      = 1'b0;
          led_d      = (start_mode == MODE_SHIFT || start_mode == MODE_BOUNCE) ? 8'h01 : 8'h00;
        end
      end
      default: begin
        if (STOP) begin
          state_d    = IDLE;
          led_d      = '0;
          step_cnt_d = '0;
          seq_cnt_d  = '0;
          dir_d      = 1'b0;
        end else if (step_cnt_q == step_last) begin
          step_cnt_d = '0;
          tick_d     = 1'b1;
          led_d      = led_next;
          dir_d      = dir_next;
          if (seq_end) begin
            seq_cnt_d = seq_cnt_q + 8'd1;
            if (repeat_q != '0 && seq_cnt_d == repeat_q) begin
              done_d    = 1'b1;
              state_d   = IDLE;
              seq_cnt_d = '0;
            end
          end
        end else begin
          step_cnt_d = step_cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      step_cnt_q <= '0;
      seq_cnt_q  <= '0;
      led_q      <= '0;
      tick_q     <= 1'b0;
      done_q     <= 1'b0;
      dir_q      <= 1'b0;
      mode_q     <= MODE_COUNT;
      step_q     <= STEP_W'(DEFAULT_STEP);
      repeat_q   <= '0;
    end else begin
      state_q    <= state_d;
      step_cnt_q <= step_cnt_d;
      seq_cnt_q  <= seq_cnt_d;
      led_q      <= led_d;
      tick_q     <= tick_d;
      done_q     <= done_d;
      dir_q      <= dir_d;
      mode_q     <= mode_d;
      step_q     <= step_d;
      repeat_q   <= repeat_d;
    end
  end

  assign CFG_READY = (state_q == IDLE);
  assign BUSY      = (state_q == RUN);
  assign TICK      = tick_q;
  assign DONE      = done_q;
  assign LED       = led_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Scoreboard bench for led_sequencer: expected ticks come from a closed-form pattern model.
module tb_led_sequencer;
  localparam int unsigned STEP_W = 32;

  logic              CLK = 1'b0;
  logic              RST_N = 1'b0;
  logic              CFG_VALID = 1'b0;
  logic              CFG_READY;
  logic [1:0]        CFG_MODE = '0;
  logic [STEP_W-1:0] CFG_STEP = '0;
  logic [7:0]        CFG_REPEAT = '0;
  logic              START = 1'b0;
  logic              STOP = 1'b0;
  logic              BUSY;
  logic              TICK;
  logic              DONE;
  logic [7:0]        LED;

  led_sequencer #(.STEP_W(STEP_W), .DEFAULT_STEP(10)) dut (
    .CLK(CLK), .RST_N(RST_N), .CFG_VALID(CFG_VALID), .CFG_READY(CFG_READY),
    .CFG_MODE(CFG_MODE), .CFG_STEP(CFG_STEP), .CFG_REPEAT(CFG_REPEAT),
    .START(START), .STOP(STOP), .BUSY(BUSY), .TICK(TICK), .DONE(DONE), .LED(LED)
  );

  always #5 CLK = ~CLK;

  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0]  led;
    bit          done;
    int unsigned at;
  } exp_t;
  exp_t sb[$];

  logic [1:0]  m_mode = 2'd0;
  int unsigned m_step = 10;
  int unsigned m_rep  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // LED after k steps from the start of a run.
  function automatic logic [7:0] pat(input logic [1:0] m, input int unsigned k);
    int unsigned p;
    case (m)
      2'd0: return 8'(k % 256);
      2'd1: return 8'(1 << (k % 8));
      2'd2: begin
        p = k % 14;
        return (p <= 7) ? 8'(1 << p) : 8'(1 << (14 - p));
      end
      default: return (k % 2 == 1) ? 8'hFF : 8'h00;
    endcase
  endfunction

  function automatic int unsigned seq_len(input logic [1:0] m);
    case (m)
      2'd0: return 256;
      2'd1: return 8;
      2'd2: return 14;
      default: return 2;
    endcase
  endfunction

  always @(negedge CLK) begin
    exp_t e;
    if (RST_N === 1'b1) begin
      if (TICK === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tick_unexpected: got TICK=1 LED=%0h expected no TICK (cycle %0d)", LED, cyc);
        end else begin
          e = sb.pop_front();
          chk("tick_cycle", cyc, e.at);
          chk("tick_led", LED, e.led);
          chk("tick_done", DONE, e.done);
        end
      end else if (DONE !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL done_without_tick: got DONE=%b expected 0 (cycle %0d)", DONE, cyc);
      end
    end
  end

  // stop_at: cycles after the start edge at which STOP (or reset) is sampled; 0 = run to DONE.
  task automatic run_seq(input bit cfg, input logic [1:0] m, input int unsigned s,
                         input int unsigned r, input int unsigned stop_at,
                         input bit use_rst, input bit poke);
    int unsigned se, n, start_e, guard;
    exp_t e;
    @(posedge CLK); #1;
    if (cfg) begin
      CFG_VALID  = 1'b1;
      CFG_MODE   = m;
      CFG_STEP   = STEP_W'(s);
      CFG_REPEAT = 8'(r);
      m_mode = m; m_step = s; m_rep = r;
    end
    START   = 1'b1;
    start_e = cyc + 1;
    se = (m_step == 0) ? 1 : m_step;
    if (stop_at == 0) n = m_rep * seq_len(m_mode);
    else begin
      n = (stop_at - 1) / se;
      if (m_rep != 0 && n > m_rep * seq_len(m_mode)) n = m_rep * seq_len(m_mode);
    end
    for (int unsigned j = 1; j <= n; j++) begin
      e.led  = pat(m_mode, j);
      e.done = (m_rep != 0) && (j == m_rep * seq_len(m_mode));
      e.at   = start_e + j * se;
      sb.push_back(e);
    end
    @(posedge CLK); #1;
    START = 1'b0;
    CFG_VALID = 1'b0;
    if (poke) begin
      chk("cfg_ready_in_run", CFG_READY, 1'b0);
      CFG_VALID = 1'b1; CFG_MODE = 2'd0; CFG_STEP = 7; CFG_REPEAT = 9;
      @(posedge CLK); #1;
      CFG_VALID = 1'b0;
    end
    if (stop_at != 0) begin
      while (cyc < start_e + stop_at - 1) begin @(posedge CLK); #1; end
      if (use_rst) begin
        @(negedge CLK); #1;
        chk("led_before_reset", LED, pat(m_mode, n));
        RST_N = 1'b0;
        #1;
        chk("led_async_reset", LED, 8'h00);
        chk("busy_async_reset", BUSY, 1'b0);
        chk("done_async_reset", DONE, 1'b0);
        m_mode = 2'd0; m_step = 10; m_rep = 0;
        @(posedge CLK); #1;
        RST_N = 1'b1;
      end else begin
        chk("busy_before_stop", BUSY, 1'b1);
        STOP = 1'b1;
        @(posedge CLK); #1;
        STOP = 1'b0;
        chk("led_after_stop", LED, 8'h00);
        chk("busy_after_stop", BUSY, 1'b0);
      end
      repeat (3) @(posedge CLK);
      #1;
      chk("ticks_pending_after_abort", sb.size(), 0);
      sb.delete();
    end else begin
      guard = 0;
      while (sb.size() != 0 && guard < n * se + 20) begin
        @(posedge CLK); #1;
        guard++;
      end
      chk("ticks_pending_at_done", sb.size(), 0);
      sb.delete();
      chk("busy_after_done", BUSY, 1'b0);
      chk("led_final", LED, pat(m_mode, n));
    end
  endtask

  initial begin
    logic [1:0] rm;
    int unsigned rs, rr, rstop;
    RST_N = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_led", LED, 8'h00);
    chk("reset_busy", BUSY, 1'b0);
    chk("reset_cfg_ready", CFG_READY, 1'b1);
    chk("reset_tick", TICK, 1'b0);
    chk("reset_done", DONE, 1'b0);
    RST_N = 1'b1;

    run_seq(1'b0, 2'd0, 0, 0, 35, 1'b0, 1'b0);  // defaults: step 10, free-running count
    run_seq(1'b1, 2'd1, 2, 1, 0, 1'b0, 1'b0);   // shift, one sequence
    @(posedge CLK); #1;
    START = 1'b1; STOP = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0; STOP = 1'b0;
    chk("start_stop_idle_busy", BUSY, 1'b0);
    chk("stop_idle_led", LED, 8'h00);
    repeat (4) @(posedge CLK);
    run_seq(1'b1, 2'd2, 1, 2, 0, 1'b0, 1'b0);   // bounce, two sequences
    run_seq(1'b1, 2'd3, 0, 3, 0, 1'b0, 1'b1);   // blink step 0 with ignored config write
    run_seq(1'b0, 2'd0, 0, 0, 0, 1'b0, 1'b0);   // shadow regs must still be blink/0/3
    run_seq(1'b1, 2'd0, 3, 0, 18, 1'b0, 1'b0);  // STOP on the tick after LED 0x05

    for (int k = 0; k < 8; k++) begin
      rm = 2'($urandom_range(0, 3));
      rs = $urandom_range(0, 3);
      if (rm == 2'd0 && rs > 1) rs = 1;
      if ($urandom_range(0, 1) == 1) begin
        rr = 0;
        rstop = $urandom_range(4, 60);
      end else begin
        rr = $urandom_range(1, 2);
        rstop = 0;
      end
      run_seq(1'b1, rm, rs, rr, rstop, 1'b0, 1'b0);
    end

    run_seq(1'b1, 2'd0, 1, 0, 52, 1'b1, 1'b0);  // reset mid-run at LED 0x33
    run_seq(1'b0, 2'd0, 0, 0, 25, 1'b0, 1'b0);  // step back to default 10

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
